// File: rtl/uart_pkg.sv
// Shared definitions for the 12-byte command link, used by both the receive and transmit sides.
package uart_pkg;
   localparam int CMD_BYTES = 12;
   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_t;

   typedef logic [CMD_BYTES-1:0][7:0] cmd_buf_t;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line with falling-edge detect.
// All flops reset to 1 so an idle-high line never produces a spurious edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic fall
);
   logic r_meta;
   logic r_q;
   logic r_prev;

   // synchronise the line and keep one cycle of history for the edge detector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
         r_prev <= r_q;
      end
   end

   assign q    = r_q;
   assign fall = r_prev & ~r_q;
endmodule

// File: rtl/uart_receive.sv
// 8N1 receiver that reassembles 12-byte commands; only complete, well-framed packets reach cmd_buf.
// Framing errors and over-long inter-byte gaps drop the partial packet and raise a one-clock flag.
module uart_receive
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int GAP_TIMEOUT  = 16
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     data_in,
   output cmd_buf_t cmd_buf,
   output logic     cmd_valid,
   output logic     frame_err,
   output logic     timeout_err,
   output logic     busy
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int GAP_W = $clog2(GAP_TIMEOUT * CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT * CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_BYTE = 4'(CMD_BYTES - 1);

   logic w_rx;
   logic w_fall;

   uart_rx_state_t   r_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_cnt;
   logic [3:0]       r_byte_idx;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [7:0]       r_shift;
   cmd_buf_t         r_asm;
   cmd_buf_t         r_cmd_buf;
   logic             r_cmd_valid;
   logic             r_frame_err;
   logic             r_timeout_err;
   logic             r_busy;

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (data_in),
      .q    (w_rx),
      .fall (w_fall)
   );

   // frame FSM, bit/byte/gap counters, assembly buffer and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_clk_cnt     <= '0;
         r_bit_cnt     <= 3'd0;
         r_byte_idx    <= 4'd0;
         r_gap_cnt     <= '0;
         r_shift       <= 8'd0;
         r_asm         <= '0;
         r_cmd_buf     <= '0;
         r_cmd_valid   <= 1'b0;
         r_frame_err   <= 1'b0;
         r_timeout_err <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_cmd_valid   <= 1'b0;
         r_frame_err   <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               // a start edge beats a timeout landing on the same clock
               if (w_fall) begin
                  r_state   <= START;
                  r_bit_cnt <= 3'd0;
                  r_clk_cnt <= '0;
                  r_busy    <= 1'b1;
               end else if (r_byte_idx != 4'd0) begin
                  if (r_gap_cnt == GAP_LAST) begin
                     r_timeout_err <= 1'b1;
                     r_byte_idx    <= 4'd0;
                     r_gap_cnt     <= '0;
                     r_busy        <= 1'b0;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt;
               end
            end
            START: begin
               if (r_clk_cnt == HALF_LAST) begin
                  r_clk_cnt <= '0;
                  if (!w_rx) begin
                     r_state <= DATA;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= (r_byte_idx != 4'd0);
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt          <= '0;
                  r_shift[r_bit_cnt] <= w_rx;
                  r_bit_cnt          <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= STOP;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt <= '0;
                  r_state   <= IDLE;
                  r_gap_cnt <= '0;
                  if (w_rx) begin
                     r_asm[r_byte_idx] <= r_shift;
                     if (r_byte_idx == LAST_BYTE) begin
                        r_cmd_buf             <= r_asm;
                        r_cmd_buf[CMD_BYTES-1] <= r_shift;
                        r_cmd_valid           <= 1'b1;
                        r_byte_idx            <= 4'd0;
                        r_busy                <= 1'b0;
                     end else begin
                        r_byte_idx <= r_byte_idx + 4'd1;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     r_byte_idx  <= 4'd0;
                     r_busy      <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_buf     = r_cmd_buf;
   assign cmd_valid   = r_cmd_valid;
   assign frame_err   = r_frame_err;
   assign timeout_err = r_timeout_err;
   assign busy        = r_busy;
endmodule
